// File: rtl/micro_hash_miner.sv
// micro_hash_miner
// ----------------
// Nonce-search engine around the 24-bit toy hash. A 12-byte header plus a
// 32-bit nonce form a 16-byte message block; each try runs ROUNDS rounds of
// the two-phase round function, adds the chaining words and compares H0/H1
// against the target. The search stops at the first passing nonce or when
// the requested number of tries is used up.
//
// Handshake: start is accepted only while busy is low (IDLE). busy rises the
// cycle after start is accepted and stays high through the single-cycle done
// pulse; a new start is accepted in the cycle right after done. found,
// nonce_out and hash_out are valid from the done cycle and held until the
// next search completes. abort drops back to IDLE without a done pulse.
//
// Optional feature macro: MICRO_HASH_STATS_EN adds the hash_count output, a
// saturating count of completed hash evaluations (FINAL cycles).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   start        request a search (IDLE only)
//   abort        cancel a search in LOAD/ROUND/FINAL
//   header       header bytes 0..11, byte i at [8i+7:8i]
//   nonce_start  first nonce to try
//   tries        number of nonces to try (0 = immediate done)
//   target       pass threshold for H0 and H1 (strict less-than)
//   busy         high in every state except IDLE
//   done         one-cycle end-of-search pulse
//   found        a passing nonce was found
//   nonce_out    passing nonce or last nonce tried
//   hash_out     {H0,H1,H2} for nonce_out
//   hash_count   (MICRO_HASH_STATS_EN only) saturating FINAL-cycle count
//   dbg_state    current FSM state encoding

module micro_hash_miner #(
  parameter int ROUNDS  = 32,
  parameter int K_SPLIT = 17,
  parameter int TRY_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [95:0]      header,
  input  logic [31:0]      nonce_start,
  input  logic [TRY_W-1:0] tries,
  input  logic [7:0]       target,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [31:0]      nonce_out,
  output logic [23:0]      hash_out,
`ifdef MICRO_HASH_STATS_EN
  output logic [31:0]      hash_count,
`endif
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [7:0] IV0 = 8'h01;
  localparam logic [7:0] IV1 = 8'h89;
  localparam logic [7:0] IV2 = 8'hFE;
  localparam logic [7:0] K_LO = 8'h99;
  localparam logic [7:0] K_HI = 8'hA1;
  localparam logic [6:0] LAST_ROUND = 7'(ROUNDS - 1);
  localparam logic [6:0] SPLIT      = 7'(K_SPLIT);

  state_e state_q, state_d;

  // Captured search request
  logic [95:0]      hdr_q;
  logic [31:0]      nonce_q;
  logic [TRY_W-1:0] tries_left_q;
  logic [7:0]       target_q;

  // Hash datapath
  logic [7:0] a_q, b_q, c_q;
  logic [6:0] t_q;
  // Sliding schedule window: win_q[j] holds W[t+j] during round t
  logic [7:0] win_q [16];

  // Result registers
  logic        found_q;
  logic [31:0] nonce_out_q;
  logic [23:0] hash_out_q;

  // Combinational round / final values
  logic [7:0] x_c, k_c;
  logic [7:0] h0_c, h1_c, h2_c;
  logic       pass_c, last_round_c, last_try_c;

  always_comb begin
    if (t_q < SPLIT) begin
      k_c = K_LO;
      x_c = a_q ^ b_q;
    end else begin
      k_c = K_HI;
      x_c = a_q | b_q;
    end
  end

  assign h0_c         = IV0 + a_q;
  assign h1_c         = IV1 + b_q;
  assign h2_c         = IV2 + c_q;
  // target=0 can never pass since nothing is below zero
  assign pass_c       = (h0_c < target_q) && (h1_c < target_q);
  assign last_round_c = (t_q == LAST_ROUND);
  assign last_try_c   = (tries_left_q == TRY_W'(1));

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        // start has priority over abort in IDLE; abort alone does nothing
        if (start) state_d = (tries == '0) ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        state_d = abort ? S_IDLE : S_ROUND;
      end
      S_ROUND: begin
        if (abort)             state_d = S_IDLE;
        else if (last_round_c) state_d = S_FINAL;
      end
      S_FINAL: begin
        if (abort)                    state_d = S_IDLE;
        else if (pass_c || last_try_c) state_d = S_DONE;
        else                          state_d = S_LOAD;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    dbg_state = state_q;
  end

  assign found     = found_q;
  assign nonce_out = nonce_out_q;
  assign hash_out  = hash_out_q;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_q        <= '0;
      nonce_q      <= '0;
      tries_left_q <= '0;
      target_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c_q          <= '0;
      t_q          <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
      found_q      <= 1'b0;
      nonce_out_q  <= '0;
      hash_out_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            hdr_q        <= header;
            nonce_q      <= nonce_start;
            tries_left_q <= tries;
            target_q     <= target;
            if (tries == '0) begin
              found_q     <= 1'b0;
              nonce_out_q <= nonce_start;
              hash_out_q  <= '0;
            end
          end
        end
        S_LOAD: begin
          for (int i = 0; i < 12; i++) win_q[i] <= hdr_q[8*i +: 8];
          for (int i = 0; i < 4; i++)  win_q[12+i] <= nonce_q[8*i +: 8];
          a_q <= IV0;
          b_q <= IV1;
          c_q <= IV2;
          t_q <= '0;
        end
        S_ROUND: begin
          a_q <= b_q ^ c_q;
          b_q <= {c_q[3:0], 4'h0};
          c_q <= x_c + k_c + win_q[0];
          t_q <= t_q + 7'd1;
          // Shift the window and append W[t+16] = W[t+13] | (W[t+7] ^ W[t+2])
          for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
          win_q[15] <= win_q[13] | (win_q[7] ^ win_q[2]);
        end
        S_FINAL: begin
          if (!abort) begin
            if (pass_c || last_try_c) begin
              found_q     <= pass_c;
              nonce_out_q <= nonce_q;
              hash_out_q  <= {h0_c, h1_c, h2_c};
            end else begin
              nonce_q      <= nonce_q + 32'd1;
              tries_left_q <= tries_left_q - TRY_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MICRO_HASH_STATS_EN
  logic [31:0] hash_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hash_count_q <= '0;
    end else if (state_q == S_FINAL && hash_count_q != 32'hFFFF_FFFF) begin
      hash_count_q <= hash_count_q + 32'd1;
    end
  end

  assign hash_count = hash_count_q;
`endif

endmodule

// File: tb/tb_micro_hash_miner.sv
// Bench for micro_hash_miner: a reference hash model predicts each search
// outcome (found / nonce / hash / done cycle), pushes it to a queue when the
// search starts and compares it when done is observed.

module tb_micro_hash_miner;

  localparam int ROUNDS  = 32;
  localparam int K_SPLIT = 17;
  localparam int TRY_W   = 16;
  localparam int CYC     = ROUNDS + 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             start;
  logic             abort;
  logic [95:0]      header;
  logic [31:0]      nonce_start;
  logic [TRY_W-1:0] tries;
  logic [7:0]       target;
  logic             busy;
  logic             done;
  logic             found;
  logic [31:0]      nonce_out;
  logic [23:0]      hash_out;
  logic [2:0]       dbg_state;
`ifdef MICRO_HASH_STATS_EN
  logic [31:0]      hash_count;
`endif

  micro_hash_miner #(.ROUNDS(ROUNDS), .K_SPLIT(K_SPLIT), .TRY_W(TRY_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .header(header), .nonce_start(nonce_start), .tries(tries), .target(target),
    .busy(busy), .done(done), .found(found), .nonce_out(nonce_out),
    .hash_out(hash_out),
`ifdef MICRO_HASH_STATS_EN
    .hash_count(hash_count),
`endif
    .dbg_state(dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  // scoreboard: {found, nonce_out, hash_out} and done cycle
  logic [56:0] exp_q[$];
  int          exp_cyc_q[$];

  // last completed-search results, as predicted by the bench
  logic        last_found;
  logic [31:0] last_nonce;
  logic [23:0] last_hash;

  function automatic logic [23:0] model_hash(input logic [95:0] hdr, input logic [31:0] n);
    logic [7:0] w [64];
    logic [7:0] a, b, c, x, k, na, nb, nc, h0, h1, h2;
    for (int t = 0; t < 12; t++) w[t] = hdr[8*t +: 8];
    for (int i = 0; i < 4; i++)  w[12+i] = n[8*i +: 8];
    for (int t = 16; t < ROUNDS; t++) w[t] = w[t-3] | (w[t-9] ^ w[t-14]);
    a = 8'h01; b = 8'h89; c = 8'hFE;
    for (int t = 0; t < ROUNDS; t++) begin
      if (t < K_SPLIT) begin k = 8'h99; x = a ^ b; end
      else             begin k = 8'hA1; x = a | b; end
      na = b ^ c;
      nb = c << 4;
      nc = x + k + w[t];
      a = na; b = nb; c = nc;
    end
    h0 = 8'h01 + a;
    h1 = 8'h89 + b;
    h2 = 8'hFE + c;
    return {h0, h1, h2};
  endfunction

  function automatic logic [95:0] rand_hdr();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // Predict the search result and push it to the scoreboard
  task automatic predict(input logic [95:0] hdr, input logic [31:0] ns,
                         input logic [TRY_W-1:0] tr, input logic [7:0] tgt);
    logic        ef;
    logic [31:0] en, n;
    logic [23:0] eh, h;
    int          ec;
    ef = 1'b0; en = ns; eh = '0; ec = 1;
    for (int i = 0; i < int'(tr); i++) begin
      n  = ns + 32'(i);
      h  = model_hash(hdr, n);
      en = n; eh = h; ec = (i + 1) * CYC + 1;
      if (h[23:16] < tgt && h[15:8] < tgt) begin
        ef = 1'b1;
        break;
      end
    end
    exp_q.push_back({ef, en, eh});
    exp_cyc_q.push_back(ec);
  endtask

  // Drive one search, wait for done, compare against the scoreboard.
  // Call in an IDLE cycle (1 time unit after a rising edge).
  task automatic run_search(input string name, input logic [95:0] hdr,
                            input logic [31:0] ns, input logic [TRY_W-1:0] tr,
                            input logic [7:0] tgt, input bit glitch);
    int          n;
    bit          seen;
    bit          busy_ok;
    logic [56:0] e;
    int          ec;
    predict(hdr, ns, tr, tgt);
    header = hdr; nonce_start = ns; tries = tr; target = tgt; start = 1'b1;
    n = 0; seen = 1'b0; busy_ok = 1'b1;
    while (!seen && n < int'(tr) * CYC + 10) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) start = 1'b0;
      if (glitch && n == 5) begin
        start = 1'b1; header = rand_hdr(); nonce_start = $urandom();
        tries = TRY_W'($urandom_range(1, 3)); target = 8'($urandom_range(0, 255));
      end
      if (glitch && n == 6) start = 1'b0;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s timeout: no done after %0d cycles", name, n);
    end
    e  = exp_q.pop_front();
    ec = exp_cyc_q.pop_front();
    checks++;
    if (n !== ec) begin
      failures++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, n, ec);
    end
    checks++;
    if (found !== e[56]) begin
      failures++;
      $display("FAIL %s found: got %0b expected %0b", name, found, e[56]);
    end
    checks++;
    if (nonce_out !== e[55:24]) begin
      failures++;
      $display("FAIL %s nonce_out: got %08h expected %08h", name, nonce_out, e[55:24]);
    end
    checks++;
    if (hash_out !== e[23:0]) begin
      failures++;
      $display("FAIL %s hash_out: got %06h expected %06h", name, hash_out, e[23:0]);
    end
    checks++;
    if (!busy_ok) begin
      failures++;
      $display("FAIL %s busy: dropped low before done", name);
    end
    last_found = e[56]; last_nonce = e[55:24]; last_hash = e[23:0];
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done: done=%0b busy=%0b expected 0/0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    header = '0; nonce_start = '0; tries = '0; target = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, found, nonce_out, hash_out} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b done=%0b found=%0b nonce=%08h hash=%06h expected all 0",
               busy, done, found, nonce_out, hash_out);
    end
`ifdef MICRO_HASH_STATS_EN
    checks++;
    if (hash_count !== 32'd0) begin
      failures++;
      $display("FAIL reset_hash_count: got %0d expected 0", hash_count);
    end
`endif
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_tries();
    run_search("zero_tries", rand_hdr(), 32'h1234_5678, '0, 8'hFF, 1'b0);
  endtask

  task automatic test_no_pass();
    run_search("no_pass_3", rand_hdr(), 32'h0000_0100, TRY_W'(3), 8'h00, 1'b0);
  endtask

  task automatic test_wrap();
    run_search("nonce_wrap", rand_hdr(), 32'hFFFF_FFFF, TRY_W'(2), 8'h00, 1'b0);
  endtask

  task automatic test_easy_pass();
    run_search("easy_pass", rand_hdr(), $urandom(), TRY_W'(16), 8'hFF, 1'b1);
  endtask

  task automatic test_mid_target();
    for (int r = 0; r < 3; r++)
      run_search("mid_target", rand_hdr(), $urandom(), TRY_W'(12), 8'h40, 1'b0);
  endtask

  // target equal to max(H0,H1) must fail; one above must pass
  task automatic test_target_boundary();
    logic [95:0] hdr;
    logic [31:0] ns;
    logic [23:0] h;
    logic [7:0]  m;
    hdr = rand_hdr(); ns = $urandom();
    h = model_hash(hdr, ns);
    m = (h[23:16] > h[15:8]) ? h[23:16] : h[15:8];
    run_search("boundary_eq", hdr, ns, TRY_W'(1), m, 1'b0);
    if (m != 8'hFF) run_search("boundary_above", hdr, ns, TRY_W'(1), m + 8'd1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_search("b2b_first", rand_hdr(), $urandom(), TRY_W'(1), 8'h00, 1'b0);
    run_search("b2b_second", rand_hdr(), $urandom(), TRY_W'(2), 8'hFF, 1'b0);
  endtask

  task automatic test_abort();
    int n;
    bit saw_done;
    header = rand_hdr(); nonce_start = $urandom(); tries = TRY_W'(4); target = 8'h00;
    start = 1'b1; saw_done = 1'b0;
    for (n = 1; n <= 21; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
      if (done === 1'b1) saw_done = 1'b1;
      if (n == 20) abort = 1'b1;
    end
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy: got %0b expected 0", busy);
    end
    repeat (5) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abort_done: got done pulse expected none");
    end
    checks++;
    if (found !== last_found || nonce_out !== last_nonce || hash_out !== last_hash) begin
      failures++;
      $display("FAIL abort_outputs: got %0b/%08h/%06h expected %0b/%08h/%06h",
               found, nonce_out, hash_out, last_found, last_nonce, last_hash);
    end
  endtask

  task automatic test_reset_mid_search();
    header = rand_hdr(); nonce_start = $urandom(); tries = TRY_W'(4); target = 8'h00;
    start = 1'b1;
    for (int n = 1; n <= 41; n++) begin
      @(posedge clk); #1;
      if (n == 1) start = 1'b0;
      if (n == 40) reset = 1'b1;
    end
    reset = 1'b0;
    checks++;
    if ({busy, done, found, nonce_out, hash_out} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: busy=%0b done=%0b found=%0b nonce=%08h hash=%06h expected all 0",
               busy, done, found, nonce_out, hash_out);
    end
    last_found = 1'b0; last_nonce = '0; last_hash = '0;
  endtask

`ifdef MICRO_HASH_STATS_EN
  task automatic test_stats();
    run_search("stats_a", rand_hdr(), $urandom(), TRY_W'(3), 8'h00, 1'b0);
    run_search("stats_b", rand_hdr(), $urandom(), TRY_W'(2), 8'h00, 1'b0);
    checks++;
    if (hash_count !== 32'd5) begin
      failures++;
      $display("FAIL stats_hash_count: got %0d expected 5", hash_count);
    end
  endtask
`endif

  initial begin
    last_found = 1'b0; last_nonce = '0; last_hash = '0;
    test_reset();
    test_zero_tries();
    test_no_pass();
    test_wrap();
    test_easy_pass();
    test_mid_target();
    test_target_boundary();
    test_back_to_back();
    test_abort();
    test_reset_mid_search();
`ifdef MICRO_HASH_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
